// File: rtl/ahb_slave_if_if.sv
// Bus bundle for ahb_slave_if: the AHB-Lite slave-side signals and the
// downstream transaction port, with slave (DUT) and master (driver) views.
interface ahb_slave_if_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_hsel;
  logic [ADDR_WIDTH-1:0] i_haddr;
  logic                  i_hwrite;
  logic [1:0]            i_htrans;
  logic [2:0]            i_hsize;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic                  i_hready;
  logic                  o_hreadyout;
  logic                  o_hresp;
  logic [DATA_WIDTH-1:0] o_hrdata;

  // Request handshake: a request transfers on a rising edge where
  // o_valid & i_ready; once o_valid rises, o_addr/o_rd0_wr1/o_wr_data stay
  // stable and o_valid stays high until that edge. i_rd_valid is a one-cycle
  // strobe qualifying i_rd_data for the single outstanding read.
  logic                  o_valid;
  logic                  o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  i_ready;
  logic                  i_rd_valid;
  logic [DATA_WIDTH-1:0] i_rd_data;

  modport slave (
    input  i_hsel, i_haddr, i_hwrite, i_htrans, i_hsize, i_hwdata, i_hready,
    output o_hreadyout, o_hresp, o_hrdata,
    output o_valid, o_rd0_wr1, o_addr, o_wr_data,
    input  i_ready, i_rd_valid, i_rd_data
  );

  modport master (
    output i_hsel, i_haddr, i_hwrite, i_htrans, i_hsize, i_hwdata, i_hready,
    input  o_hreadyout, o_hresp, o_hrdata,
    input  o_valid, o_rd0_wr1, o_addr, o_wr_data,
    output i_ready, i_rd_valid, i_rd_data
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: turns each accepted transfer into one request on
// the valid/ready port and stretches the data phase until it completes.
module ahb_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         i_clk_ahb,
  input  logic         i_rst_ahb,
  ahb_slave_if_if.slave bus,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WREQ  = 3'd2,
    S_RREQ  = 3'd3,
    S_RWAIT = 3'd4,
    S_ERR1  = 3'd5,
    S_ERR2  = 3'd6
  } state_t;

  state_t                state_q, state_n;
  logic                  hreadyout_q, hreadyout_n;
  logic                  hresp_q, hresp_n;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_n;
  logic                  valid_q, valid_n;
  logic                  rd0_wr1_q, rd0_wr1_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_n;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_n;
  logic                  accept;
  logic                  size_err;

  assign accept = bus.i_hsel & bus.i_htrans[1] & bus.i_hready;

  // Only byte, aligned halfword and aligned word transfers are supported.
  assign size_err = (bus.i_hsize > 3'd2) ||
                    ((bus.i_hsize == 3'd1) && bus.i_haddr[0]) ||
                    ((bus.i_hsize == 3'd2) && (bus.i_haddr[1:0] != 2'b00));

  always_comb begin
    state_n     = state_q;
    hreadyout_n = hreadyout_q;
    hresp_n     = hresp_q;
    hrdata_n    = hrdata_q;
    valid_n     = valid_q;
    rd0_wr1_n   = rd0_wr1_q;
    addr_n      = addr_q;
    wr_data_n   = wr_data_q;
    lat_addr_n  = lat_addr_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_n     = S_IDLE;
        hreadyout_n = 1'b1;
        hresp_n     = 1'b0;
        if (accept) begin
          lat_addr_n  = bus.i_haddr;
          hreadyout_n = 1'b0;
          if (size_err) begin
            state_n = S_ERR1;
            hresp_n = 1'b1;
          end else if (bus.i_hwrite) begin
            state_n = S_WDATA;
          end else begin
            state_n   = S_RREQ;
            valid_n   = 1'b1;
            rd0_wr1_n = 1'b0;
            addr_n    = bus.i_haddr;
          end
        end
      end
      S_WDATA: begin
        state_n   = S_WREQ;
        wr_data_n = bus.i_hwdata;
        valid_n   = 1'b1;
        rd0_wr1_n = 1'b1;
        addr_n    = lat_addr_q;
      end
      S_WREQ: begin
        if (bus.i_ready) begin
          state_n     = S_IDLE;
          valid_n     = 1'b0;
          hreadyout_n = 1'b1;
        end
      end
      S_RREQ: begin
        if (bus.i_ready) begin
          state_n = S_RWAIT;
          valid_n = 1'b0;
        end
      end
      S_RWAIT: begin
        if (bus.i_rd_valid) begin
          state_n     = S_IDLE;
          hrdata_n    = bus.i_rd_data;
          hreadyout_n = 1'b1;
        end
      end
      S_ERR1: begin
        state_n     = S_ERR2;
        hreadyout_n = 1'b1;
        hresp_n     = 1'b1;
      end
      default: begin
        state_n     = S_IDLE;
        hreadyout_n = 1'b1;
        hresp_n     = 1'b0;
        valid_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      valid_q     <= 1'b0;
      rd0_wr1_q   <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      lat_addr_q  <= '0;
    end else begin
      state_q     <= state_n;
      hreadyout_q <= hreadyout_n;
      hresp_q     <= hresp_n;
      hrdata_q    <= hrdata_n;
      valid_q     <= valid_n;
      rd0_wr1_q   <= rd0_wr1_n;
      addr_q      <= addr_n;
      wr_data_q   <= wr_data_n;
      lat_addr_q  <= lat_addr_n;
    end
  end

  assign bus.o_hreadyout = hreadyout_q;
  assign bus.o_hresp     = hresp_q;
  assign bus.o_hrdata    = hrdata_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_rd0_wr1   = rd0_wr1_q;
  assign bus.o_addr      = addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: cycle-exact checks of the AHB response and
// a request scoreboard fed by a handshake monitor.
module tb_ahb_slave_if;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 1 + AW + DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  ahb_slave_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ahb_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk_ahb (clk),
    .i_rst_ahb (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Single-slave system: bus HREADY is this slave's HREADYOUT.
  assign bus.i_hready = bus.o_hreadyout;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  // ---------------- request monitor ----------------
  always @(posedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready)
      got_q.push_back({bus.o_rd0_wr1, bus.o_addr,
                       (bus.o_rd0_wr1 ? bus.o_wr_data : {DW{1'b0}})});
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check_eq(input string tag, input logic [RW-1:0] got,
                          input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.i_hsel   = 1'b0;
    bus.i_htrans = 2'b00;
  endtask

  task automatic addr_phase(input logic wr, input logic [AW-1:0] a,
                            input logic [2:0] sz);
    bus.i_hsel   = 1'b1;
    bus.i_htrans = 2'b10;
    bus.i_hwrite = wr;
    bus.i_haddr  = a;
    bus.i_hsize  = sz;
  endtask

  task automatic sb_check(input string tag);
    check_eq($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq(tag, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [2:0] sz,
                          input logic [DW-1:0] d);
    addr_phase(1'b1, a, sz);
    tick();
    bus_idle();
    bus.i_hwdata = d;
    tick();
    bus.i_hwdata = '0;
    tick();
    check_eq("wr_done_hready", bus.o_hreadyout, 1'b1);
    check_eq("wr_done_hresp", bus.o_hresp, 1'b0);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic err_pattern(input string tag);
    check_eq({tag, "_e0_hready"}, bus.o_hreadyout, 1'b0);
    check_eq({tag, "_e0_hresp"}, bus.o_hresp, 1'b1);
    check_eq({tag, "_e0_valid"}, bus.o_valid, 1'b0);
    tick();
    check_eq({tag, "_e1_hready"}, bus.o_hreadyout, 1'b1);
    check_eq({tag, "_e1_hresp"}, bus.o_hresp, 1'b1);
  endtask

  logic [AW-1:0] err_addr[3];
  logic [2:0]    err_size[3];
  logic [1:0]    ign_trans[3];
  logic          ign_sel[3];

  // ---------------- stimulus ----------------
  initial begin
    err_addr  = '{32'h3002, 32'h3000, 32'h3001};
    err_size  = '{3'd2, 3'd3, 3'd1};
    ign_trans = '{2'b00, 2'b01, 2'b10};
    ign_sel   = '{1'b1, 1'b1, 1'b0};

    bus_idle();
    bus.i_hwrite   = 1'b0;
    bus.i_haddr    = '0;
    bus.i_hsize    = 3'd0;
    bus.i_hwdata   = '0;
    bus.i_ready    = 1'b0;
    bus.i_rd_valid = 1'b0;
    bus.i_rd_data  = '0;

    // Reset values
    rst = 1'b1;
    tick();
    check_eq("rst_hreadyout", bus.o_hreadyout, 1'b1);
    check_eq("rst_hresp", bus.o_hresp, 1'b0);
    check_eq("rst_hrdata", bus.o_hrdata, 32'h0);
    check_eq("rst_valid", bus.o_valid, 1'b0);
    check_eq("rst_rd0_wr1", bus.o_rd0_wr1, 1'b0);
    check_eq("rst_addr", bus.o_addr, 32'h0);
    check_eq("rst_wr_data", bus.o_wr_data, 32'h0);
    check_eq("rst_state", dbg_state, 3'd0);
    tick();
    rst = 1'b0;

    // Single write
    bus.i_ready = 1'b1;
    addr_phase(1'b1, 32'h1000, 3'd2);
    tick();
    bus_idle();
    bus.i_hwdata = 32'hDEADBEEF;
    check_eq("w1_e0_hready", bus.o_hreadyout, 1'b0);
    check_eq("w1_e0_valid", bus.o_valid, 1'b0);
    tick();
    bus.i_hwdata = '0;
    check_eq("w1_e1_valid", bus.o_valid, 1'b1);
    check_eq("w1_e1_rw", bus.o_rd0_wr1, 1'b1);
    check_eq("w1_e1_addr", bus.o_addr, 32'h1000);
    check_eq("w1_e1_wdata", bus.o_wr_data, 32'hDEADBEEF);
    check_eq("w1_e1_hready", bus.o_hreadyout, 1'b0);
    tick();
    check_eq("w1_e2_hready", bus.o_hreadyout, 1'b1);
    check_eq("w1_e2_valid", bus.o_valid, 1'b0);
    check_eq("w1_e2_hresp", bus.o_hresp, 1'b0);
    exp_q.push_back({1'b1, 32'h1000, 32'hDEADBEEF});
    sb_check("w1_req");

    // Read with latency; a stray i_rd_valid during RREQ is ignored
    addr_phase(1'b0, 32'h2004, 3'd2);
    tick();
    bus_idle();
    bus.i_rd_valid = 1'b1;
    bus.i_rd_data  = 32'hBAD0BAD0;
    check_eq("r1_e0_valid", bus.o_valid, 1'b1);
    check_eq("r1_e0_rw", bus.o_rd0_wr1, 1'b0);
    check_eq("r1_e0_addr", bus.o_addr, 32'h2004);
    check_eq("r1_e0_hready", bus.o_hreadyout, 1'b0);
    tick();
    bus.i_rd_valid = 1'b0;
    check_eq("r1_e1_valid", bus.o_valid, 1'b0);
    check_eq("r1_e1_hready", bus.o_hreadyout, 1'b0);
    check_eq("r1_e1_hrdata", bus.o_hrdata, 32'h0);
    tick();
    check_eq("r1_e2_hready", bus.o_hreadyout, 1'b0);
    tick();
    check_eq("r1_e3_hready", bus.o_hreadyout, 1'b0);
    bus.i_rd_valid = 1'b1;
    bus.i_rd_data  = 32'h12345678;
    tick();
    bus.i_rd_valid = 1'b0;
    check_eq("r1_done_hready", bus.o_hreadyout, 1'b1);
    check_eq("r1_done_hrdata", bus.o_hrdata, 32'h12345678);
    exp_q.push_back({1'b0, 32'h2004, 32'h0});
    sb_check("r1_req");

    // Backpressure: i_ready low for 5 WREQ cycles
    bus.i_ready = 1'b0;
    addr_phase(1'b1, 32'h40, 3'd2);
    tick();
    bus_idle();
    bus.i_hwdata = 32'hCAFEF00D;
    tick();
    bus.i_hwdata = '0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", bus.o_valid, 1'b1);
      check_eq("bp_addr", bus.o_addr, 32'h40);
      check_eq("bp_wdata", bus.o_wr_data, 32'hCAFEF00D);
      check_eq("bp_hready", bus.o_hreadyout, 1'b0);
      tick();
    end
    check_eq("bp_valid_held", bus.o_valid, 1'b1);
    bus.i_ready = 1'b1;
    tick();
    check_eq("bp_done_hready", bus.o_hreadyout, 1'b1);
    check_eq("bp_done_valid", bus.o_valid, 1'b0);
    check_eq("bp_hrdata_hold", bus.o_hrdata, 32'h12345678);
    exp_q.push_back({1'b1, 32'h40, 32'hCAFEF00D});
    sb_check("bp_req");

    // Pipelined write 0x10 then read 0x14; read address waits on the bus
    addr_phase(1'b1, 32'h10, 3'd2);
    tick();
    addr_phase(1'b0, 32'h14, 3'd2);
    bus.i_hwdata = 32'h11111111;
    check_eq("pp_e0_hready", bus.o_hreadyout, 1'b0);
    tick();
    bus.i_hwdata = '0;
    check_eq("pp_w_valid", bus.o_valid, 1'b1);
    check_eq("pp_w_rw", bus.o_rd0_wr1, 1'b1);
    check_eq("pp_w_addr", bus.o_addr, 32'h10);
    tick();
    check_eq("pp_w_done_hready", bus.o_hreadyout, 1'b1);
    check_eq("pp_w_done_valid", bus.o_valid, 1'b0);
    tick();
    bus_idle();
    check_eq("pp_r_valid", bus.o_valid, 1'b1);
    check_eq("pp_r_rw", bus.o_rd0_wr1, 1'b0);
    check_eq("pp_r_addr", bus.o_addr, 32'h14);
    check_eq("pp_r_hready", bus.o_hreadyout, 1'b0);
    tick();
    check_eq("pp_r_valid_drop", bus.o_valid, 1'b0);
    bus.i_rd_valid = 1'b1;
    bus.i_rd_data  = 32'hA5A5A5A5;
    tick();
    bus.i_rd_valid = 1'b0;
    check_eq("pp_r_done_hready", bus.o_hreadyout, 1'b1);
    check_eq("pp_r_done_hrdata", bus.o_hrdata, 32'hA5A5A5A5);
    exp_q.push_back({1'b1, 32'h10, 32'h11111111});
    exp_q.push_back({1'b0, 32'h14, 32'h0});
    sb_check("pp_req");

    // Errors: misaligned word, oversize, misaligned halfword
    for (int i = 0; i < 3; i++) begin
      addr_phase(1'b1, err_addr[i], err_size[i]);
      tick();
      bus_idle();
      err_pattern("err");
      tick();
      check_eq("err_after_hresp", bus.o_hresp, 1'b0);
      check_eq("err_after_hready", bus.o_hreadyout, 1'b1);
      check_eq("err_after_valid", bus.o_valid, 1'b0);
    end
    // A new transfer presented in ERR2 is accepted there
    addr_phase(1'b0, 32'h3002, 3'd2);
    tick();
    bus_idle();
    tick();
    addr_phase(1'b0, 32'h3004, 3'd4);
    tick();
    bus_idle();
    err_pattern("err2acc");
    tick();
    check_eq("err2acc_after_hresp", bus.o_hresp, 1'b0);
    // Legal narrow transfers at the boundary are not flagged
    do_write(32'h3002, 3'd1, 32'h0000BEEF);
    do_write(32'h3003, 3'd0, 32'h000000AB);
    sb_check("err_req");

    // Ignored transfers: IDLE, BUSY, and NONSEQ without hsel
    for (int i = 0; i < 3; i++) begin
      bus.i_hsel   = ign_sel[i];
      bus.i_htrans = ign_trans[i];
      bus.i_hwrite = 1'b1;
      bus.i_haddr  = 32'h50;
      bus.i_hsize  = 3'd2;
      tick();
      check_eq("ign_hready", bus.o_hreadyout, 1'b1);
      check_eq("ign_valid", bus.o_valid, 1'b0);
      tick();
      check_eq("ign_hready2", bus.o_hreadyout, 1'b1);
      check_eq("ign_hresp", bus.o_hresp, 1'b0);
    end
    bus_idle();
    sb_check("ign_req");

    // Reset in RWAIT
    addr_phase(1'b0, 32'h60, 3'd2);
    tick();
    bus_idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_valid", bus.o_valid, 1'b0);
    check_eq("mrst_hready", bus.o_hreadyout, 1'b1);
    check_eq("mrst_hrdata", bus.o_hrdata, 32'h0);
    check_eq("mrst_addr", bus.o_addr, 32'h0);
    check_eq("mrst_hresp", bus.o_hresp, 1'b0);
    bus.i_rd_valid = 1'b1;
    bus.i_rd_data  = 32'h77;
    tick();
    tick();
    bus.i_rd_valid = 1'b0;
    check_eq("mrst_late_hrdata", bus.o_hrdata, 32'h0);
    check_eq("mrst_late_hready", bus.o_hreadyout, 1'b1);
    check_eq("mrst_late_valid", bus.o_valid, 1'b0);
    exp_q.push_back({1'b0, 32'h60, 32'h0});
    sb_check("mrst_req");

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

- AHB-Lite slave front end of the AHB-to-AHB bridge.
- Sits directly upstream of the bridge's AHB master stage and feeds its transaction port: `valid/ready`, `rd0_wr1`, `addr`, `wr_data`, with read data returned via `rd_valid/rd_data`.
- Converts each accepted AHB transfer into exactly one transaction request and holds the AHB data phase with HREADYOUT low until the request completes.
- Rejects misaligned or oversize transfers with a two-cycle ERROR response.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width

Ports (one clock; reset is synchronous and active-high):
- i_clk_ahb  in  1  AHB clock; all logic on rising edge
- i_rst_ahb  in  1  synchronous active-high reset
- i_hsel  in  1  slave select
- i_haddr  in  ADDR_WIDTH  transfer address
- i_hwrite  in  1  1 = write, 0 = read
- i_htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- i_hsize  in  3  transfer size
- i_hwdata  in  DATA_WIDTH  write data (data phase)
- i_hready  in  1  bus HREADY (HREADYIN)
- o_hreadyout  out  1  slave ready / data-phase end
- o_hresp  out  1  0 OKAY, 1 ERROR
- o_hrdata  out  DATA_WIDTH  read data
- o_valid  out  1  transaction request valid
- o_rd0_wr1  out  1  request type
- o_addr  out  ADDR_WIDTH  request address
- o_wr_data  out  DATA_WIDTH  request write data
- i_ready  in  1  downstream accepts request
- i_rd_valid  in  1  downstream read data valid
- i_rd_data  in  DATA_WIDTH  downstream read data

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** o_hreadyout=1, o_hresp=0, o_hrdata=0, o_valid=0, o_rd0_wr1=0, o_addr=0, o_wr_data=0. FSM goes to IDLE.
- **Accept condition.** A transfer is accepted only in IDLE or ERR2 when i_hsel & i_htrans[1] & i_hready are all 1.
  - On accept, latch haddr and hwrite.
  - IDLE/BUSY htrans, or hsel=0, get a zero-wait OKAY and no request.
- **Error check at accept.** ERROR if i_hsize>2, OR hsize=1 with haddr[0]≠0, OR hsize=2 with haddr[1:0]≠0. In that case go to ERR1 and issue no request.
- **FSM states:**
  - IDLE: hreadyout=1, hresp=0. Accepted write → WDATA; accepted read → RREQ; error → ERR1.
  - WDATA: hreadyout=0. Capture i_hwdata into o_wr_data; set o_valid=1, o_rd0_wr1=1, o_addr=latched address → WREQ.
  - WREQ: hreadyout=0, o_valid held. On i_ready=1, drop o_valid, set hreadyout=1 → IDLE.
  - RREQ: o_valid=1, o_rd0_wr1=0, hreadyout=0. On i_ready, drop o_valid → RWAIT.
  - RWAIT: hreadyout=0. On i_rd_valid, load o_hrdata=i_rd_data, set hreadyout=1 → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts a new transfer exactly as IDLE does, else → IDLE.
- **Request stability.** While o_valid=1, o_addr, o_rd0_wr1 and o_wr_data are stable; o_valid never drops without i_ready.
- **Read-data sampling.** i_rd_valid is sampled only in RWAIT and ignored elsewhere; at most one outstanding request.
- **o_hrdata hold.** o_hrdata holds its last value until the next read completes.
- **No partial writes.** i_hsize is used only for the alignment/size check and is not forwarded; downstream always sees full-width writes.
- **Reset mid-operation.** An in-flight request or data phase is dropped; all outputs return to their reset values on the next edge.

## Timing
- Address accepted on edge E0.
- **Write:** WDATA in cycle E0–E1. o_valid=1 from E1 onward. If i_ready=1 in the first WREQ cycle, o_hreadyout=1 from E2. Minimum 2 wait states; each extra i_ready=0 cycle adds one.
- **Read:** o_valid=1 from E0 onward. With i_ready=1 immediately, RWAIT from E1. If i_rd_valid arrives k cycles into RWAIT (k≥0), o_hrdata is valid and o_hreadyout=1 at E2+k.
- **Error:** hresp=1 with hreadyout=0 for one cycle, then hresp=1 with hreadyout=1 for one cycle.
- **Back-to-back:** the cycle that ends a data phase (hreadyout=1) also accepts the next address phase. No idle cycle is inserted between transfers.

## Test plan
- **Single write.** Write, haddr=0x1000, hsize=2, hwdata=0xDEADBEEF, i_ready=1 → one o_valid pulse with o_addr=0x1000, o_wr_data=0xDEADBEEF, o_rd0_wr1=1; hreadyout low for exactly 2 cycles; hresp=0.
- **Read with latency.** Read, haddr=0x2004, i_rd_valid 3 cycles after handshake with i_rd_data=0x12345678 → o_hrdata=0x12345678 when hreadyout rises; exactly one request.
- **Backpressure.** i_ready held 0 for 5 cycles during a write → o_valid/o_addr/o_wr_data stable for all 5 cycles; hreadyout stays 0 until the handshake.
- **Pipelined traffic.** Write 0x10 then read 0x14 back-to-back → two requests in order; read address accepted in the write's completion cycle; no dropped or duplicated requests.
- **Errors and ignored transfers.**
  - hsize=2, haddr=0x3002 → hresp=1 for 2 cycles, hreadyout pattern 0 then 1, no o_valid.
  - htrans=IDLE with hsel=1 → no request, hreadyout stays 1.
- **Reset mid-read.** Assert i_rst_ahb in RWAIT → next edge: o_valid=0, o_hreadyout=1, o_hrdata=0; a later i_rd_valid is ignored.
